kernel_window_builder: RTL and testbench

Producer side of the 5x5 gradient path. Consumes a raster pixel stream (one pixel per valid cycle, row-major, frame start flagged) and builds a KERNEL_SIZE x KERNEL_SIZE window from KERNEL_SIZE-1 line buffers and a window shift register. Drives the window, window-valid and start-of-frame into the Gx/Gy gradient stage. Windows are emitted only when fully inside the image; there is no padding.

---
 rtl/kernel_window_pkg.sv | 26 ++
 rtl/kwb_line_buffer.sv | 41 ++++
 rtl/kernel_window_builder.sv | 175 +++++++++++++++++
 tb/tb_kernel_window_builder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_window_pkg.sv
// Shared types and helpers for the kernel window builder slice.
package kernel_window_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  // Pixel type at the default pixel width.
  typedef logic [DEFAULT_DATA_WIDTH-1:0] pixel_t;

  // Frame tracking states.
  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    RUN      = 2'd1,
    DONE     = 2'd2
  } kwb_state_e;

  // Column counter width; at least one bit.
  function automatic int unsigned col_cnt_width(input int unsigned img_width);
    return (img_width > 1) ? $clog2(img_width) : 1;
  endfunction

  // Row counter width; at least one bit.
  function automatic int unsigned row_cnt_width(input int unsigned img_height);
    return (img_height > 1) ? $clog2(img_height) : 1;
  endfunction

endpackage

// File: rtl/kwb_line_buffer.sv
// Fixed-delay line buffer: a ring RAM of DEPTH entries whose single pointer is
// read then overwritten on each enabled cycle, so o_data is the sample written
// exactly DEPTH enables earlier. RAM contents are not reset.
module kwb_line_buffer
  import kernel_window_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 640
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int unsigned PW = col_cnt_width(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         ptr_q;

  // Ring pointer advances once per enabled sample.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      ptr_q <= '0;
    end else if (i_enable) begin
      ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  // Storage write; no reset so it maps onto RAM.
  always_ff @(posedge i_clk) begin
    if (i_enable) begin
      mem[ptr_q] <= i_data;
    end
  end

  assign o_data = mem[ptr_q];

endmodule

// File: rtl/kernel_window_builder.sv
// Builds a KERNEL_SIZE x KERNEL_SIZE sliding window over a raster pixel stream
// using KERNEL_SIZE-1 chained line buffers and a window shift register.
// Windows are emitted only when fully inside the image (no padding).
// Optional: define KERNEL_WINDOW_EOF_EN to add o_end_of_frame, flagging the
// window completed by the last pixel of the frame.
module kernel_window_builder
  import kernel_window_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KERNEL_SIZE = 5,
  parameter int unsigned IMG_WIDTH   = 640,
  parameter int unsigned IMG_HEIGHT  = 480
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic [DATA_WIDTH-1:0] i_pixel,
  input  logic                  i_pixel_valid,
  input  logic                  i_start_of_frame,
  output logic [DATA_WIDTH-1:0] o_image_kernel_buffer [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
  output logic                  o_data_valid,
  output logic                  o_start_of_frame
`ifdef KERNEL_WINDOW_EOF_EN
  ,
  output logic                  o_end_of_frame
`endif
);

  localparam int unsigned K  = KERNEL_SIZE;
  localparam int unsigned CW = col_cnt_width(IMG_WIDTH);
  localparam int unsigned RW = row_cnt_width(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_SIZE - 1);

  kwb_state_e    state_q, state_d;
  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;

  logic accept;
  logic win_done;
  logic win_first;
  logic last_pix;

  logic [DATA_WIDTH-1:0] lb_out [0:K-2];
  logic [DATA_WIDTH-1:0] win_q  [0:K-1][0:K-1];
  logic [DATA_WIDTH-1:0] win_d  [0:K-1][0:K-1];

  // Pixel acceptance and position of the current pixel; SOF always restarts at (0,0).
  always_comb begin
    accept    = i_pixel_valid && (i_start_of_frame || (state_q == RUN));
    col_cur   = i_start_of_frame ? '0 : col_q;
    row_cur   = i_start_of_frame ? '0 : row_q;
    win_done  = accept && (col_cur >= COL_FIRST) && (row_cur >= ROW_FIRST);
    win_first = win_done && (col_cur == COL_FIRST) && (row_cur == ROW_FIRST);
    last_pix  = (col_cur == COL_LAST) && (row_cur == ROW_LAST);
  end

  // Frame FSM and raster counters.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      if (last_pix) begin
        state_d = DONE;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = RUN;
        if (col_cur == COL_LAST) begin
          col_d = '0;
          row_d = row_cur + 1'b1;
        end else begin
          col_d = col_cur + 1'b1;
          row_d = row_cur;
        end
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q <= WAIT_SOF;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Chained line buffers: buffer k outputs the pixel k+1 lines above the input.
  for (genvar k = 0; k < K - 1; k++) begin : g_lb
    logic [DATA_WIDTH-1:0] lb_in;
    if (k == 0) begin : g_head
      assign lb_in = i_pixel;
    end else begin : g_chain
      assign lb_in = lb_out[k-1];
    end
    kwb_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH)
    ) u_line_buffer (
      .i_clk    (i_clk),
      .i_areset (i_areset),
      .i_enable (accept),
      .i_data   (lb_in),
      .o_data   (lb_out[k])
    );
  end

  // Window shift: columns move left, the new right column is the vertical pixel slice.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K) - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      for (int r = 0; r < int'(K) - 1; r++) begin
        win_d[r][K-1] = lb_out[int'(K) - 2 - r];
      end
      win_d[K-1][K-1] = i_pixel;
    end
  end

  // Window shift register.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K); c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      win_q <= win_d;
    end
  end

  // Registered outputs; the published window holds between valids.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      o_data_valid     <= 1'b0;
      o_start_of_frame <= 1'b0;
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K); c++) begin
          o_image_kernel_buffer[r][c] <= '0;
        end
      end
    end else begin
      o_data_valid     <= win_done;
      o_start_of_frame <= win_first;
      if (win_done) begin
        o_image_kernel_buffer <= win_d;
      end
    end
  end

`ifdef KERNEL_WINDOW_EOF_EN
  // End-of-frame flag rides with the window completed by the last pixel.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      o_end_of_frame <= 1'b0;
    end else begin
      o_end_of_frame <= win_done && last_pix;
    end
  end
`endif

endmodule

// File: tb/tb_kernel_window_builder.sv
// Scoreboard bench for kernel_window_builder: the driver keeps a frame image and
// pushes the expected window for every in-image position; a monitor pops and
// compares whenever o_data_valid is seen.
module tb_kernel_window_builder;
  import kernel_window_pkg::*;

  localparam int K    = 5;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int DW   = 8;
  localparam int WINS = (W - K + 1) * (H - K + 1);
  localparam int WB   = K * K * DW;

  logic   clk = 1'b0;
  logic   rst;
  pixel_t pix;
  logic   pv;
  logic   sof;
  logic [DW-1:0] kb [0:K-1][0:K-1];
  logic   dv;
  logic   osof;
`ifdef KERNEL_WINDOW_EOF_EN
  logic   oeof;
`endif

  kernel_window_builder #(
    .DATA_WIDTH  (DW),
    .KERNEL_SIZE (K),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .i_clk                 (clk),
    .i_areset              (rst),
    .i_pixel               (pix),
    .i_pixel_valid         (pv),
    .i_start_of_frame      (sof),
    .o_image_kernel_buffer (kb),
    .o_data_valid          (dv),
    .o_start_of_frame      (osof)
`ifdef KERNEL_WINDOW_EOF_EN
    ,
    .o_end_of_frame        (oeof)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WB-1:0] win;
    logic          sof;
    logic          eof;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stall_en = 0;

  // Windows observed by the monitor, for scenario-level checks.
  logic [7:0] seen00 [$];
  logic [7:0] seen44 [$];
  logic       seensof[$];
  int         n_valid_total = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: image store indexed by raster position.
  bit         m_in_frame = 0;
  int         m_r = 0;
  int         m_c = 0;
  logic [7:0] img [0:H-1][0:W-1];

  task automatic model_accept(input logic [7:0] p, input bit s);
    exp_t e;
    if (s) begin
      m_in_frame = 1;
      m_r = 0;
      m_c = 0;
    end
    if (m_in_frame) begin
      img[m_r][m_c] = p;
      if (m_r >= K - 1 && m_c >= K - 1) begin
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            e.win[(i*K+j)*DW +: DW] = img[m_r-K+1+i][m_c-K+1+j];
        e.sof = (m_r == K - 1 && m_c == K - 1);
        e.eof = (m_r == H - 1 && m_c == W - 1);
        q.push_back(e);
      end
      if (m_c == W - 1) begin
        m_c = 0;
        if (m_r == H - 1) m_in_frame = 0;
        else m_r++;
      end else begin
        m_c++;
      end
    end
  endtask

  task automatic drive(input logic [7:0] p, input bit s);
    while (stall_en && $urandom_range(1, 0) == 0) begin
      @(posedge clk); #1;
      pv  = 1'b0;
      pix = 8'($urandom);
      sof = 1'($urandom_range(1, 0));
    end
    @(posedge clk); #1;
    pv  = 1'b1;
    pix = p;
    sof = s;
    model_accept(p, s);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pv  = 1'b0;
      sof = 1'b0;
    end
  endtask

  // Sends frame pixels from (0,0) up to but excluding (stop_r, stop_c).
  task automatic send_frame(input bit pattern, input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r < stop_r || (r == stop_r && c < stop_c))
          drive(pattern ? 8'(r * 16 + c) : 8'($urandom), (r == 0 && c == 0));
      end
    end
  endtask

  task automatic send_junk(input int n);
    for (int i = 0; i < n; i++) drive(8'($urandom), 1'b0);
  endtask

  task automatic end_scn(input string name, input int base, input int exp_wins);
    idle(1);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk); #1;
    chk({name, "_pending"}, 256'(q.size()), 256'(0));
    chk({name, "_count"}, 256'(n_valid_total - base), 256'(exp_wins));
  endtask

  task automatic chk_zero(input string name);
    logic [WB-1:0] f;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        f[(i*K+j)*DW +: DW] = kb[i][j];
    chk({name, "_win"}, 256'(f), 256'(0));
    chk({name, "_valid"}, 256'(dv), 256'(0));
    chk({name, "_sof"}, 256'(osof), 256'(0));
`ifdef KERNEL_WINDOW_EOF_EN
    chk({name, "_eof"}, 256'(oeof), 256'(0));
`endif
  endtask

  // Pixel-valid as seen by the DUT at the last edge.
  logic pv_prev = 1'b0;
  always @(posedge clk) pv_prev <= pv;

  // Monitor: compare every presented window against the scoreboard.
  exp_t          mon_e;
  logic [WB-1:0] mon_got;
  always @(negedge clk) begin
    if (!rst) begin
      if (dv) begin
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            mon_got[(i*K+j)*DW +: DW] = kb[i][j];
        chk("valid_follows_pixel", 256'(pv_prev), 256'(1));
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_window: got window %0h expected none", mon_got);
        end else begin
          mon_e = q.pop_front();
          chk("window", 256'(mon_got), 256'(mon_e.win));
          chk("window_sof", 256'(osof), 256'(mon_e.sof));
`ifdef KERNEL_WINDOW_EOF_EN
          chk("window_eof", 256'(oeof), 256'(mon_e.eof));
`endif
        end
        seen00.push_back(kb[0][0]);
        seen44.push_back(kb[K-1][K-1]);
        seensof.push_back(osof);
        n_valid_total++;
      end else begin
        chk("sof_without_valid", 256'(osof), 256'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst = 1'b1;
    pv  = 1'b0;
    pix = '0;
    sof = 1'b0;
    #3;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Pixels before any SOF are ignored.
    base = n_valid_total;
    send_junk(20);
    end_scn("wait_sof", base, 0);

    // Scenario 1: continuous coordinate-pattern frame.
    base = n_valid_total;
    send_frame(1'b1, H, 0);
    end_scn("s1", base, WINS);
    if (seen00.size() >= base + WINS) begin
      chk("s1_first_00", 256'(seen00[base]), 256'(8'h00));
      chk("s1_first_44", 256'(seen44[base]), 256'(8'h44));
      chk("s1_first_sof", 256'(seensof[base]), 256'(1));
      chk("s1_last_00", 256'(seen00[base+WINS-1]), 256'(8'h13));
      chk("s1_last_44", 256'(seen44[base+WINS-1]), 256'(8'h57));
    end else begin
      chk("s1_window_log", 256'(seen00.size() - base), 256'(WINS));
    end

    // Pixels after a completed frame (DONE) are ignored.
    base = n_valid_total;
    send_junk(20);
    end_scn("done", base, 0);

    // Scenario 2: same frame with ~50% valid gaps.
    stall_en = 1;
    base = n_valid_total;
    send_frame(1'b1, H, 0);
    end_scn("s2", base, WINS);
    stall_en = 0;

    // Scenario 4: abort at (3,2) then a full frame.
    base = n_valid_total;
    send_frame(1'b1, 3, 2);
    send_frame(1'b1, H, 0);
    end_scn("s4", base, WINS);
    if (seensof.size() >= base + 1)
      chk("s4_first_sof", 256'(seensof[base]), 256'(1));

    // Random data, abort after row 4 windows, then a stalled random frame.
    base = n_valid_total;
    send_frame(1'b0, 5, 3);
    stall_en = 1;
    send_frame(1'b0, H, 0);
    stall_en = 0;
    end_scn("abort_rand", base, (W - K + 1) + WINS);

    // Scenario 5: async reset mid row 4, then a full frame.
    base = n_valid_total;
    send_frame(1'b1, 4, 6);
    @(posedge clk); #1;
    pv = 1'b0;
    @(negedge clk); #1;
    chk("pre_reset_count", 256'(n_valid_total - base), 256'(2));
    chk("pre_reset_pending", 256'(q.size()), 256'(0));
    #1 rst = 1'b1;
    #1;
    chk_zero("async_reset");
    q.delete();
    m_in_frame = 0;
    @(negedge clk);
    rst = 1'b0;
    base = n_valid_total;
    send_frame(1'b1, H, 0);
    end_scn("s5", base, WINS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
